// File: rtl/input_debounce_ctrl.sv
// ============================================================================
// input_debounce_ctrl
// ----------------------------------------------------------------------------
// Front end for the two memory-mapped switch banks. Each raw bank is
// brought into the clock domain through a two-flop synchroniser and then
// filtered by its own settle FSM. A new value is committed only after it has
// been seen on DEBOUNCE_CYC + 1 consecutive edges. The CPU reads the committed
// values, plus a sticky change-status word. Reading that word clears it. A
// level interrupt is raised while any change flag is pending.
//
// Ports
//   clk       in   1       system clock, all state on the rising edge
//   rst_n     in   1       asynchronous active-low reset
//   input1    in   DATA_W  raw bank 0 switches (asynchronous to clk)
//   input2    in   DATA_W  raw bank 1 switches (asynchronous to clk)
//   addr      in   32      CPU load address
//   rd_en     in   1       CPU load strobe, one cycle per access
//   data_out  out  32      read data, zero-extended, combinational on addr
//   irq       out  1       OR of the pending change flags
//
// Address map (full 32-bit compare, any other address reads 0)
//   ADDR_IN0   committed bank 0 value
//   ADDR_IN1   committed bank 1 value
//   ADDR_STAT  {30'b0, chg1, chg0}, cleared by a load strobe to this address
// ============================================================================
module input_debounce_ctrl #(
    parameter int          DATA_W       = 5,
    parameter int          DEBOUNCE_CYC = 16,      // must be >= 2
    parameter logic [31:0] ADDR_IN0     = 32'hA0,
    parameter logic [31:0] ADDR_IN1     = 32'hA4,
    parameter logic [31:0] ADDR_STAT    = 32'hA8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] input1,
    input  logic [DATA_W-1:0] input2,
    input  logic [31:0]       addr,
    input  logic              rd_en,
    output logic [31:0]       data_out,
    output logic              irq
);

    // Settle counter runs 0 .. DEBOUNCE_CYC-1.
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // Per-bank FSM states.
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_SETTLING = 1'b1;

    // Both banks share the same filter, so they are handled as a packed array
    // and the filter is replicated by a generate loop.
    logic [1:0][DATA_W-1:0] raw_bank;
    logic [1:0][DATA_W-1:0] stable_bank;
    logic [1:0]             chg_set;     // commit that changed the value
    logic [1:0]             chg;         // sticky change flags
    logic                   stat_clear;

    assign raw_bank = {input2, input1};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic [DATA_W-1:0] sync1;
        logic [DATA_W-1:0] syn;
        logic [DATA_W-1:0] cand;
        logic [DATA_W-1:0] stable_r;
        logic [CNT_W-1:0]  cnt;
        logic [0:0]        state;
        logic              commit;

        // Two-flop synchroniser. The raw switches are asynchronous, so only
        // syn (the second stage) is allowed to reach any decision logic.
        // NOTE: non-blocking assignments keep every flop sampling pre-edge
        // values; blocking here would collapse the two stages into one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= '0;
                syn   <= '0;
            end else begin
                sync1 <= raw_bank[b];
                syn   <= sync1;
            end
        end

        // Settle FSM. STABLE holds while syn matches the committed value.
        // SETTLING tracks a candidate and restarts the count whenever syn
        // moves. A candidate that equals the old committed value (bounce
        // back) still commits, but it raises no change event.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_STABLE;
                cand     <= '0;
                cnt      <= '0;
                stable_r <= '0;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (syn != stable_r) begin
                            cand  <= syn;
                            cnt   <= '0;
                            state <= ST_SETTLING;
                        end
                    end
                    ST_SETTLING: begin
                        if (syn != cand) begin
                            cand <= syn;
                            cnt  <= '0;
                        end else if (cnt != CNT_LAST) begin
                            cnt <= cnt + CNT_W'(1);
                        end else begin
                            stable_r <= cand;
                            state    <= ST_STABLE;
                        end
                    end
                    default: state <= ST_STABLE;
                endcase
            end
        end

        // The commit condition is the final SETTLING branch above, so the
        // change flag can be set on the same edge that updates stable_r.
        assign commit         = (state == ST_SETTLING) && (syn == cand) &&
                                (cnt == CNT_LAST);
        assign chg_set[b]     = commit && (cand != stable_r);
        assign stable_bank[b] = stable_r;
    end

    // Status flags. A set on the same edge as a clear wins, so an event that
    // commits during a status read is reported by the next read.
    assign stat_clear = rd_en && (addr == ADDR_STAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg <= '0;
        end else begin
            chg <= (chg & ~{2{stat_clear}}) | chg_set;
        end
    end

    assign irq = |chg;

    // Read mux. It does not depend on rd_en, so a status read returns the
    // value from before the clear that happens at the end of the same cycle.
    // NOTE: data_out is given its default before any branch, so no path can
    // leave it unassigned and no latch is inferred.
    always_comb begin
        data_out = '0;
        if (addr == ADDR_IN0) begin
            data_out = 32'(stable_bank[0]);
        end else if (addr == ADDR_IN1) begin
            data_out = 32'(stable_bank[1]);
        end else if (addr == ADDR_STAT) begin
            data_out = {30'b0, chg};
        end
    end

endmodule

// File: tb/tb_input_debounce_ctrl.sv
// ============================================================================
// tb_input_debounce_ctrl
// ----------------------------------------------------------------------------
// Bench for input_debounce_ctrl. It runs directed sequences for reset, a
// clean step, a glitch, a bounce, status read and clear, and a reset while
// settling. A table of address/strobe vectors checks the read mux. A long
// random run is compared against a run-length reference model. The model
// says a bank commits its synced value on the edge where that value has been
// seen on DEBOUNCE_CYC + 1 consecutive edges. It raises an event only when
// the committed value actually changes.
// ============================================================================
module tb_input_debounce_ctrl;

    localparam int          DATA_W = 5;
    localparam int          D      = 16;
    localparam logic [31:0] A_IN0  = 32'hA0;
    localparam logic [31:0] A_IN1  = 32'hA4;
    localparam logic [31:0] A_STAT = 32'hA8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic [31:0]       addr;
    logic              rd_en;
    logic [31:0]       data_out;
    logic              irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    input_debounce_ctrl #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CYC (D),
        .ADDR_IN0     (A_IN0),
        .ADDR_IN1     (A_IN1),
        .ADDR_STAT    (A_STAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .input1   (input1),
        .input2   (input2),
        .addr     (addr),
        .rd_en    (rd_en),
        .data_out (data_out),
        .irq      (irq)
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_d1      [2];   // raw seen one edge ago
    logic [DATA_W-1:0] m_d2      [2];   // raw seen two edges ago (what the filter sees)
    logic [DATA_W-1:0] m_run_val [2];
    int                m_run_len [2];
    logic [DATA_W-1:0] m_stab    [2];
    logic [1:0]        m_chg;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b]      = '0;
            m_d2[b]      = '0;
            m_run_val[b] = '0;
            m_run_len[b] = 0;
            m_stab[b]    = '0;
        end
        m_chg = '0;
    endtask

    // Called right after each rising edge. The inputs still hold the values
    // that the edge sampled.
    task automatic model_step();
        logic [1:0]        set;
        logic [DATA_W-1:0] s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        set = '0;
        for (int b = 0; b < 2; b++) begin
            s = m_d2[b];
            if (s == m_run_val[b]) begin
                if (m_run_len[b] < 1000) m_run_len[b]++;
            end else begin
                m_run_val[b] = s;
                m_run_len[b] = 1;
            end
            if (m_run_len[b] == D + 1 && s != m_stab[b]) begin
                m_stab[b] = s;
                set[b]    = 1'b1;
            end
            m_d2[b] = m_d1[b];
            m_d1[b] = (b == 0) ? input1 : input2;
        end
        if (rd_en && addr == A_STAT) m_chg = '0;
        m_chg = m_chg | set;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == A_IN0)  return 32'(m_stab[0]);
        if (a == A_IN1)  return 32'(m_stab[1]);
        if (a == A_STAT) return {30'b0, m_chg};
        return 32'h0;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Advance n rising edges and settle 2 time units after the last one.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
        end
        #2;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a,
                            input logic [31:0] expected);
        addr = a;
        #1;
        check(name, data_out, expected);
    endtask

    task automatic irq_chk(input string name, input logic expected);
        check(name, {31'b0, irq}, {31'b0, expected});
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd_en;
        logic [31:0] exp_data;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Mux vectors, applied when bank0=0x15, bank1=0, chg=01.
        vecs[0] = '{A_IN0,         1'b0, 32'h15, 1'b1};
        vecs[1] = '{A_IN1,         1'b0, 32'h00, 1'b1};
        vecs[2] = '{A_STAT,        1'b0, 32'h01, 1'b1};
        vecs[3] = '{32'hAC,        1'b0, 32'h00, 1'b1};
        vecs[4] = '{32'h1000_00A0, 1'b0, 32'h00, 1'b1};
        vecs[5] = '{32'hA1,        1'b1, 32'h00, 1'b1};
        vecs[6] = '{A_STAT,        1'b1, 32'h01, 1'b1};
        vecs[7] = '{A_STAT,        1'b0, 32'h00, 1'b0};
        vecs[8] = '{A_IN0,         1'b0, 32'h15, 1'b0};

        // 1: reset with a non-zero raw input.
        rst_n  = 1'b0;
        input1 = 5'h1F;
        input2 = 5'h00;
        addr   = A_IN0;
        rd_en  = 1'b0;
        model_reset();
        edges(3);
        read_chk("rst_in0", A_IN0, 32'h0);
        read_chk("rst_stat", A_STAT, 32'h0);
        irq_chk("rst_irq", 1'b0);
        rst_n  = 1'b1;
        input1 = 5'h00;
        edges(3);

        // 2: a clean step commits on the 19th edge.
        input1 = 5'h15;
        edges(D + 2);
        read_chk("step_early", A_IN0, 32'h0);
        edges(1);
        read_chk("step_commit", A_IN0, 32'h15);
        read_chk("step_stat", A_STAT, 32'h1);
        irq_chk("step_irq", 1'b1);
        read_chk("step_in1", A_IN1, 32'h0);

        // 3: a glitch shorter than the settle time is dropped.
        input2 = 5'h07;
        edges(10);
        input2 = 5'h00;
        edges(30);
        read_chk("glitch_in1", A_IN1, 32'h0);
        read_chk("glitch_stat", A_STAT, 32'h1);

        // Table-driven mux and clear-on-read vectors.
        for (int i = 0; i < 9; i++) begin
            addr  = vecs[i].addr;
            rd_en = vecs[i].rd_en;
            #1;
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
            edges(1);
        end
        rd_en = 1'b0;

        // 4: bounce for 40 cycles, then hold 0x0A.
        for (int seg = 0; seg < 8; seg++) begin
            input1 = (seg % 2 == 0) ? 5'h0A : 5'h15;
            edges(5);
        end
        input1 = 5'h0A;
        edges(D + 2);
        read_chk("bounce_early", A_IN0, 32'h15);
        read_chk("bounce_nochg", A_STAT, 32'h0);
        edges(1);
        read_chk("bounce_commit", A_IN0, 32'h0A);
        addr  = A_STAT;
        rd_en = 1'b1;
        read_chk("bounce_stat", A_STAT, 32'h1);
        edges(1);
        rd_en = 1'b0;
        read_chk("bounce_clr", A_STAT, 32'h0);
        edges(20);
        read_chk("bounce_one_evt", A_STAT, 32'h0);
        irq_chk("bounce_irq", 1'b0);

        // 5: both flags, read and clear; then a set that lands on the clear edge.
        input1 = 5'h1F;
        input2 = 5'h1C;
        edges(D + 3);
        read_chk("stat_both", A_STAT, 32'h3);
        irq_chk("stat_both_irq", 1'b1);
        rd_en = 1'b1;
        read_chk("stat_rd", A_STAT, 32'h3);
        edges(1);
        rd_en = 1'b0;
        read_chk("stat_after", A_STAT, 32'h0);
        irq_chk("stat_after_irq", 1'b0);
        input1 = 5'h00;
        edges(5);
        input2 = 5'h03;
        edges(D + 2);
        read_chk("race_pre", A_STAT, 32'h1);
        rd_en = 1'b1;
        read_chk("race_rd", A_STAT, 32'h1);
        edges(1);
        rd_en = 1'b0;
        read_chk("race_post", A_STAT, 32'h2);
        irq_chk("race_irq", 1'b1);

        // 6: reset while settling abandons the candidate.
        input1 = 5'h1F;
        edges(8);
        rst_n = 1'b0;
        #1;
        read_chk("mid_rst_in0", A_IN0, 32'h0);
        read_chk("mid_rst_in1", A_IN1, 32'h0);
        irq_chk("mid_rst_irq", 1'b0);
        model_reset();
        edges(2);
        rst_n = 1'b1;
        edges(D + 2);
        read_chk("rel_early0", A_IN0, 32'h0);
        read_chk("rel_early1", A_IN1, 32'h0);
        edges(1);
        read_chk("rel_commit0", A_IN0, 32'h1F);
        read_chk("rel_commit1", A_IN1, 32'h03);
        read_chk("rel_stat", A_STAT, 32'h3);

        // Random run against the reference model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int sel;
            if (cyc == 1500) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (cyc == 1503) rst_n = 1'b1;
            if ($urandom_range(0, 99) < 5) input1 = DATA_W'($urandom);
            if ($urandom_range(0, 99) < 5) input2 = DATA_W'($urandom);
            sel = $urandom_range(0, 4);
            case (sel)
                0:       addr = A_IN0;
                1:       addr = A_IN1;
                2, 3:    addr = A_STAT;
                default: addr = $urandom;
            endcase
            rd_en = ($urandom_range(0, 3) == 0);
            #1;
            check($sformatf("rand%0d_data", cyc), data_out, model_read(addr));
            check($sformatf("rand%0d_irq", cyc), {31'b0, irq}, {31'b0, |m_chg});
            edges(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
